// File: rtl/spi_master_param.sv
// spi_master_param
//   Parametrised SPI master. Runs one full-duplex word transfer per accepted
//   start, supports all four CPOL/CPHA modes and NUM_SS active-low selects,
//   and returns the received word with a one-cycle done pulse.
//
//   Optional feature macro: SPI_MASTER_LSB_FIRST_EN
//     defined   -> extra input lsb_first, captured at start, selects LSB-first
//     undefined -> MSB-first only, no lsb_first port
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      transfer request, honoured only in IDLE
//   cpol       SCLK idle level
//   cpha       0: sample on leading edge, 1: sample on trailing edge
//   ss_sel     index of slave to select (out-of-range selects none)
//   data_in    word to transmit
//   lsb_first  (macro only) LSB-first transfer when 1
//   data_out   last received word
//   busy       high from LEAD through TRAIL
//   done       one-cycle pulse when data_out updates
//   sclk       SPI clock
//   mosi       master out
//   miso       master in
//   ss_n       active-low slave selects
module spi_master_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned NUM_SS  = 1,
    parameter int unsigned SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] data_in,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int unsigned EDGES = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(EDGES + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] LastEdge = CNT_W'(EDGES);
    localparam logic [CNT_W-1:0] PenEdge  = CNT_W'(EDGES - 1);
    localparam logic [DIV_W-1:0] DivLast  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StLead, StXfer, StTrail, StDone} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    edge_q, edge_d;    // SCLK edges already issued
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic [DATA_W-1:0]   tx_q, tx_d;        // bits still to be sent, next bit at the shift end
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic [NUM_SS-1:0]   sel_mask;
    logic                lsb_in;
    logic                lead_edge;
    logic                sample;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w,
                                                   input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // First sampled bit ends up at the MSB (or LSB when lsb is set).
    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w,
                                                   input logic b, input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // An out-of-range ss_sel matches no line, so no select is asserted.
    always_comb begin
        sel_mask = '0;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SS_W'(i)) begin
                sel_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        lead_edge  = 1'b0;
        sample     = 1'b0;

        case (state_q)
            StIdle: begin
                sclk_d = cpol;
                div_d  = '0;
                edge_d = '0;
                if (start) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_in;
                    ss_n_d  = ~sel_mask;
                    rx_d    = '0;
                    state_d = StLead;
                    if (!cpha) begin
                        // cpha=0 needs the first bit on the wire before edge 1
                        mosi_d = first_bit(data_in, lsb_in);
                        tx_d   = shift_tx(data_in, lsb_in);
                    end else begin
                        tx_d = data_in;
                    end
                end
            end

            StLead, StXfer: begin
                if (div_q != DivLast) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (edge_q == LastEdge) begin
                        // last half-period complete; sclk is back at cpol
                        state_d = StTrail;
                    end else begin
                        state_d   = StXfer;
                        sclk_d    = ~sclk_q;
                        edge_d    = edge_q + CNT_W'(1);
                        lead_edge = ~edge_q[0];
                        sample    = lead_edge ^ cpha_q;
                        if (sample) begin
                            rx_d = shift_rx(rx_q, miso, lsb_q);
                        end else if (edge_q != PenEdge) begin
                            // final trailing edge (cpha=0) has nothing left to send
                            mosi_d = first_bit(tx_q, lsb_q);
                            tx_d   = shift_tx(tx_q, lsb_q);
                        end
                    end
                end
            end

            StTrail: begin
                if (div_q != DivLast) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d      = '0;
                    state_d    = StDone;
                    ss_n_d     = '1;
                    data_out_d = rx_q;
                end
            end

            StDone: begin
                sclk_d  = cpol_q;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign data_out = data_out_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign busy     = (state_q == StLead) || (state_q == StXfer) || (state_q == StTrail);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param (DATA_W=8, CLK_DIV=2, NUM_SS=3).
// A behavioural SPI slave answers on miso and captures mosi; a scoreboard
// queue holds the expected result of every accepted transfer and is checked
// on each done pulse.
module tb_spi_master_param;

    localparam int DW  = 8;
    localparam int CD  = 2;
    localparam int NSS = 3;
    localparam int SSW = 2;
    localparam int LAT = 1 + CD * (2 * DW + 2);   // start-to-done cycles (37)

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           miso = 1'b0;
    logic           lsb_first = 1'b0;
    logic [SSW-1:0] ss_sel = '0;
    logic [DW-1:0]  data_in = '0;
    logic [DW-1:0]  data_out;
    logic           busy, done, sclk, mosi;
    logic [NSS-1:0] ss_n;

    always #5 clk = ~clk;

    spi_master_param #(
        .DATA_W (DW),
        .CLK_DIV(CD),
        .NUM_SS (NSS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cpol     (cpol),
        .cpha     (cpha),
        .ss_sel   (ss_sel),
        .data_in  (data_in),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [DW-1:0] sl_word = '0;
    logic [DW-1:0] sl_cap = '0;
    int            sl_edges = 0;
    int            sl_bit = 0;
    logic          cur_cpha = 1'b0;
    logic          cur_lsb = 1'b0;
    logic          prev_sclk = 1'b0;
    logic          prev_busy = 1'b0;

    function automatic logic pick(input logic [DW-1:0] w, input int b, input logic lsb);
        if (b >= DW) return 1'b0;
        return lsb ? w[b] : w[DW-1-b];
    endfunction

    initial begin
        logic lead;
        logic samp;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy !== 1'b1) begin
                sl_edges = 0;
                sl_bit   = 0;
                sl_cap   = '0;
                if (!cur_cpha) miso = pick(sl_word, 0, cur_lsb);
            end else if (busy === 1'b1 && sclk !== prev_sclk) begin
                sl_edges++;
                lead = (sl_edges % 2) == 1;
                samp = lead ? !cur_cpha : cur_cpha;
                if (samp) begin
                    sl_cap = cur_lsb ? {mosi, sl_cap[DW-1:1]} : {sl_cap[DW-2:0], mosi};
                end else if (cur_cpha) begin
                    miso = pick(sl_word, sl_bit, cur_lsb);
                    sl_bit++;
                end else begin
                    sl_bit++;
                    miso = pick(sl_word, sl_bit, cur_lsb);
                end
            end
            prev_sclk = sclk;
            prev_busy = busy;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] dout;
        logic [DW-1:0] mosi_word;
        int            t;          // cycle start was sampled, -1 = no latency check
    } exp_t;

    exp_t sb[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_data_out", data_out, e.dout);
                    check("sb_mosi_word", sl_cap, e.mosi_word);
                    check("sb_sclk_edges", sl_edges, 2 * DW);
                    check("sb_busy_at_done", busy, 1'b0);
                    if (e.t >= 0) check("sb_latency", cyc - e.t, LAT);
                end
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic           cpol;
        logic           cpha;
        logic [SSW-1:0] sel;
        logic [DW-1:0]  din;
        logic [DW-1:0]  sw;
        logic [NSS-1:0] ssn;
        logic [DW-1:0]  dout;
    } vec_t;

    vec_t vecs[8];

    task automatic run_xfer(input vec_t v, input logic lsb, input string tag);
        int   n_done;
        logic ss_bad;
        @(negedge clk);
        cpol      = v.cpol;
        cpha      = v.cpha;
        ss_sel    = v.sel;
        data_in   = v.din;
        lsb_first = lsb;
        cur_cpha  = v.cpha;
        cur_lsb   = lsb_first;
        sl_word   = v.sw;
        @(negedge clk);
        check({tag, ":idle_sclk"}, sclk, v.cpol);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{v.dout, v.din, cyc - 1});
        // inputs are don't-care after acceptance
        cpol    = ~v.cpol;
        cpha    = ~v.cpha;
        data_in = ~v.din;
        ss_sel  = ~v.sel;
        n_done  = -1;
        ss_bad  = 1'b0;
        for (int n = 1; n <= LAT + 5; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, ":busy_rise"}, busy, 1'b1);
            if (done === 1'b1) begin
                n_done = n;
                check({tag, ":ss_n_at_done"}, ss_n, {NSS{1'b1}});
                break;
            end
            if (ss_n !== v.ssn) ss_bad = 1'b1;
        end
        check({tag, ":ss_n_during"}, ss_bad, 1'b0);
        check({tag, ":done_cycle"}, n_done, LAT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d[3];
        int nd;

        vecs[0] = '{1'b0, 1'b0, 2'd0, 8'hA5, 8'h3C, 3'b110, 8'h3C};
        vecs[1] = '{1'b0, 1'b1, 2'd0, 8'hA5, 8'h3C, 3'b110, 8'h3C};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 8'hA5, 8'h3C, 3'b110, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 8'hA5, 8'h3C, 3'b110, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 8'h5A, 8'hC3, 3'b011, 8'hC3};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 8'hFF, 8'h00, 3'b101, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'hFF, 3'b111, 8'hFF};  // out-of-range select
        vecs[7] = '{1'b1, 1'b0, 2'd2, 8'h81, 8'h7E, 3'b011, 8'h7E};

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", data_out, '0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ss_n", ss_n, {NSS{1'b1}});
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_xfer(vecs[i], 1'b0, $sformatf("vec%0d", i));

`ifdef SPI_MASTER_LSB_FIRST_EN
        run_xfer('{1'b0, 1'b0, 2'd0, 8'h01, 8'h01, 3'b110, 8'h01}, 1'b1, "lsb_01");
        run_xfer('{1'b1, 1'b1, 2'd1, 8'h35, 8'hC2, 3'b101, 8'hC2}, 1'b1, "lsb_35");
`endif

        // start held high: three back-to-back transfers
        base = done_cnt;
        nd   = 0;
        d    = '{0, 0, 0};
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; ss_sel = '0; data_in = 8'hA5; lsb_first = 1'b0;
        cur_cpha = 1'b0; cur_lsb = lsb_first; sl_word = 8'h3C;
        repeat (3) sb.push_back('{8'h3C, 8'hA5, -1});
        start = 1'b1;
        for (int n = 0; n < 200 && nd < 3; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                d[nd] = cyc;
                nd++;
            end
        end
        start = 1'b0;
        repeat (60) @(negedge clk);
        check("held_done_count", done_cnt - base, 3);
        check("held_spacing_1", d[1] - d[0], LAT + 1);
        check("held_spacing_2", d[2] - d[1], LAT + 1);

        // start pulses while busy and in DONE are ignored
        base = done_cnt;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b1; ss_sel = '0; data_in = 8'hA5;
        cur_cpha = 1'b1; cur_lsb = lsb_first; sl_word = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{8'h3C, 8'hA5, cyc - 1});
        for (int n = 1; n <= LAT + 1; n++) begin
            @(negedge clk);
            start = (n == 5 || n == 10 || n == 20 || n == LAT);
        end
        start = 1'b0;
        repeat (60) @(negedge clk);
        check("pulse_done_count", done_cnt - base, 1);

        // reset in the middle of a transfer
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b1; ss_sel = 2'd1; data_in = 8'h5A;
        cur_cpha = 1'b1; cur_lsb = lsb_first; sl_word = 8'h99;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 10) rst = 1'b1;
        end
        @(negedge clk);
        check("midrst_ss_n", ss_n, {NSS{1'b1}});
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_data_out", data_out, '0);
        rst  = 1'b0;
        base = done_cnt;
        repeat (60) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);

        run_xfer(vecs[0], 1'b0, "post_rst");
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
